// File: rtl/muldiv_pkg.sv
// Shared encodings for the iterative multiply/divide unit.
package muldiv_pkg;

   localparam logic [1:0] OP_MULT  = 2'b00;
   localparam logic [1:0] OP_MULTU = 2'b01;
   localparam logic [1:0] OP_DIV   = 2'b10;
   localparam logic [1:0] OP_DIVU  = 2'b11;

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_FIX,
      S_DONE
   } state_e;

   // Fill bit replicated into lo on a divide by zero.
   localparam logic DBZ_FILL = 1'b1;

   function automatic logic op_is_div(input logic [1:0] o);
      return o[1];
   endfunction

   function automatic logic op_is_signed(input logic [1:0] o);
      return (o == OP_MULT) || (o == OP_DIV);
   endfunction

endpackage

// File: rtl/muldiv_div_step.sv
// One restoring-division iteration: shift in a dividend bit, try subtract.
module muldiv_div_step #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] rem_in,
   input  logic [WIDTH-1:0] divisor,
   input  logic             dvd_bit,
   output logic [WIDTH-1:0] rem_out,
   output logic             q_bit
);

   logic [WIDTH:0]   shifted;
   logic [WIDTH:0]   diff;
   logic [WIDTH-1:0] rem_shift;

   assign shifted   = {rem_in, dvd_bit};
   assign rem_shift = {rem_in[WIDTH-2:0], dvd_bit};
   assign diff      = shifted - {1'b0, divisor};
   // No borrow out of the top bit means the trial subtract fits.
   assign q_bit     = ~diff[WIDTH];
   assign rem_out   = q_bit ? diff[WIDTH-1:0] : rem_shift;

endmodule

// File: rtl/muldiv_iter_unit.sv
// Iterative MULT/MULTU/DIV/DIVU engine with start/busy/done handshake.
// MULDIV_FAST_MUL_EN: single-cycle combinational multiply instead of shift-add.
import muldiv_pkg::*;

module muldiv_iter_unit #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 6
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic               cancel,
   input  logic [1:0]         op,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   output logic               busy,
   output logic               done,
   output logic [2*WIDTH-1:0] result,
   output logic               div_by_zero
);

   state_e             state;
   logic [CNT_W-1:0]   cnt;
   logic [2*WIDTH-1:0] acc;
   logic [WIDTH-1:0]   opnd;
   logic               is_div_q;
   logic               sign_a;
   logic               sign_b;

   logic               a_neg;
   logic               b_neg;
   logic [WIDTH-1:0]   a_mag;
   logic [WIDTH-1:0]   b_mag;
   logic               accept;
   logic               dbz;

   assign a_neg  = op_is_signed(op) & a[WIDTH-1];
   assign b_neg  = op_is_signed(op) & b[WIDTH-1];
   assign a_mag  = a_neg ? -a : a;
   assign b_mag  = b_neg ? -b : b;
   assign accept = ((state == S_IDLE) || (state == S_DONE))
                   && start && !cancel;
   assign dbz    = op_is_div(op) && (b == '0);

   logic [WIDTH:0]     mul_sum;
   logic [2*WIDTH-1:0] mul_next;
   logic [WIDTH-1:0]   rem_next;
   logic               q_bit;
   logic [2*WIDTH-1:0] div_next;

   assign mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]}
                     + (acc[0] ? {1'b0, opnd} : '0);
   assign mul_next = {mul_sum, acc[WIDTH-1:1]};

   muldiv_div_step #(.WIDTH(WIDTH)) u_step (
      .rem_in  (acc[2*WIDTH-1:WIDTH]),
      .divisor (opnd),
      .dvd_bit (acc[WIDTH-1]),
      .rem_out (rem_next),
      .q_bit   (q_bit)
   );

   assign div_next = {rem_next, acc[WIDTH-2:0], q_bit};

   logic [2*WIDTH-1:0] prod_fix;
   logic [WIDTH-1:0]   quo_fix;
   logic [WIDTH-1:0]   rem_fix;
   logic [2*WIDTH-1:0] fix_res;

   assign prod_fix = (sign_a ^ sign_b) ? -acc : acc;
   assign quo_fix  = (sign_a ^ sign_b) ? -acc[WIDTH-1:0]
                                       : acc[WIDTH-1:0];
   assign rem_fix  = sign_a ? -acc[2*WIDTH-1:WIDTH]
                            : acc[2*WIDTH-1:WIDTH];
   assign fix_res  = is_div_q ? {rem_fix, quo_fix} : prod_fix;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= S_IDLE;
         busy        <= 1'b0;
         done        <= 1'b0;
         div_by_zero <= 1'b0;
         result      <= '0;
         cnt         <= '0;
         acc         <= '0;
         opnd        <= '0;
         is_div_q    <= 1'b0;
         sign_a      <= 1'b0;
         sign_b      <= 1'b0;
      end else begin
         done <= 1'b0;
         unique case (state)
            S_IDLE, S_DONE: begin
               state <= S_IDLE;
               busy  <= 1'b0;
               if (accept) begin
                  div_by_zero <= 1'b0;
                  is_div_q    <= op_is_div(op);
                  sign_a      <= a_neg;
                  sign_b      <= b_neg;
                  cnt         <= CNT_W'(WIDTH - 1);
                  if (dbz) begin
                     state       <= S_DONE;
                     done        <= 1'b1;
                     div_by_zero <= 1'b1;
                     result      <= {a, {WIDTH{DBZ_FILL}}};
                  end else if (op_is_div(op)) begin
                     state <= S_RUN;
                     busy  <= 1'b1;
                     acc   <= {{WIDTH{1'b0}}, a_mag};
                     opnd  <= b_mag;
                  end else begin
`ifdef MULDIV_FAST_MUL_EN
                     state <= S_FIX;
                     busy  <= 1'b1;
                     acc   <= (2*WIDTH)'(a_mag) * (2*WIDTH)'(b_mag);
`else
                     state <= S_RUN;
                     busy  <= 1'b1;
                     acc   <= {{WIDTH{1'b0}}, b_mag};
                     opnd  <= a_mag;
`endif
                  end
               end
            end
            S_RUN: begin
               if (cancel) begin
                  state <= S_IDLE;
                  busy  <= 1'b0;
               end else begin
                  acc <= is_div_q ? div_next : mul_next;
                  if (cnt == '0) begin
                     state <= S_FIX;
                  end else begin
                     cnt <= cnt - 1'b1;
                  end
               end
            end
            S_FIX: begin
               busy <= 1'b0;
               if (cancel) begin
                  state <= S_IDLE;
               end else begin
                  state  <= S_DONE;
                  done   <= 1'b1;
                  result <= fix_res;
               end
            end
         endcase
      end
   end

endmodule

// File: doc/muldiv_iter_unit.md
Name: muldiv_iter_unit

Overview:
- Parametrised iterative multiply/divide engine for the EX stage. It replaces the inline multiplier and divider in the ALU.
- Computes MULT/MULTU/DIV/DIVU and produces a packed {hi, lo} result for the HILO register.
- Uses a start/busy/done handshake; the pipeline holds EX stalled while busy is high.
- A cancel input flushes an in-flight operation on an exception or branch flush.

Parameters:
- WIDTH, 32, operand width; result is 2*WIDTH bits.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  in  1  clock; all state updates on its rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  request; sampled only in IDLE or DONE.
- cancel  in  1  synchronous abort.
- op  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU; captured with start.
- a  in  WIDTH  multiplicand or dividend; captured with start.
- b  in  WIDTH  multiplier or divisor; captured with start.
- busy  out  1  high in RUN and FIX.
- done  out  1  one-cycle pulse; result valid.
- result  out  2*WIDTH  {hi, lo}. Multiply: hi = product upper half, lo = product lower half. Divide: hi = remainder, lo = quotient.
- div_by_zero  out  1  valid with done; high for a DIV/DIVU with b==0.

Behaviour:
- Reset (rst low, asynchronous):
  - state = IDLE.
  - busy = 0, done = 0, div_by_zero = 0, result = 0.
  - Any operation in progress is discarded.
- States: IDLE, RUN, FIX, DONE.
- Timing, with start accepted in cycle 0:
  - RUN occupies cycles 1..WIDTH.
  - FIX occupies cycle WIDTH+1.
  - DONE occupies cycle WIDTH+2, with done=1 and busy=0.
  - Latency is therefore WIDTH+2 cycles.
- From DONE, the next state is IDLE. If start is high in DONE, it is accepted (back-to-back operation) and the next state is RUN.
- start while busy is ignored, and no flags are raised.
- Operand preparation: signed ops (MULT, DIV) convert operands to magnitudes at capture. The signs of a and b are registered.
- Multiply datapath: shift-add, one multiplier bit per RUN cycle, into a 2*WIDTH accumulator.
- Divide datapath: restoring, one quotient bit per RUN cycle, into WIDTH-bit quotient and remainder registers.
- FIX cycle:
  - Product is negated when sign(a) != sign(b).
  - Quotient is negated when sign(a) != sign(b).
  - Remainder takes the sign of the dividend.
  - result is loaded at the FIX to DONE edge and held until the next load.
- Division by zero: DIV/DIVU with b==0 goes directly to DONE in cycle 1, with no RUN and no FIX.
  - result = {a, all-ones}.
  - div_by_zero = 1.
- Signed overflow, DIV of MIN by -1: quotient = MIN, remainder = 0, div_by_zero = 0. No special path is used; the normal algorithm yields this.
- div_by_zero is cleared when the next start is accepted.
- cancel:
  - In RUN or FIX, the next state is IDLE; done is not pulsed and result keeps its prior value.
  - cancel together with start in IDLE or DONE: cancel wins and the start is dropped.
  - cancel in DONE: done still pulses that cycle, since the result is already committed.
- Counter: loads WIDTH-1 on start and decrements in RUN. The RUN to FIX transition occurs at count 0; the counter does not wrap.

Optional Feature:
- Macro: MULDIV_FAST_MUL_EN.
- Defined: MULT/MULTU use a single combinational WIDTH x WIDTH multiply and skip RUN. Timing is FIX in cycle 1 and DONE in cycle 2, so latency is 2. Divide is unchanged.
- Undefined: all ops are iterative as above, with no hardware multiplier inferred.

Decomposition:
- Shared package muldiv_pkg:
  - op encoding constants OP_MULT, OP_MULTU, OP_DIV, OP_DIVU.
  - state enum constants S_IDLE, S_RUN, S_FIX, S_DONE.
  - helper constant for the divide-by-zero lo value (all-ones).
- Sub-module muldiv_div_step: combinational single restoring-division iteration.
  - Inputs: partial remainder, divisor, next dividend bit.
  - Outputs: new remainder, quotient bit.

Test Plan (WIDTH=32):
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF -> done in cycle 34, result={0xFFFFFFFE, 0x00000001}, busy high in cycles 1..33.
- MULT a=-3, b=7 -> result={0xFFFFFFFF, 0xFFFFFFEB}. DIV a=-7, b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIVU a=5, b=0 -> done in cycle 1, result={0x00000005, 0xFFFFFFFF}, div_by_zero=1. The following DIVU 10/3 clears the flag and returns {1, 3}.
- DIV a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0x00000000, div_by_zero=0.
- DIVU 100/7 with cancel in cycle 10 -> busy=0 in cycle 11, no done, result unchanged. A start pulse in cycle 5 is ignored.
- rst low in cycle 15 of a MULT -> all outputs 0 immediately, without waiting for a clock edge. After release, a MULTU 2*3 returns {0, 6} in cycle 34. With MULTU 2*3 under MULDIV_FAST_MUL_EN, done occurs in cycle 2.
